// File: rtl/plot_fb.sv
// ============================================================================
// plot_fb : 160x120x3 framebuffer with plot port, clear engine and raster
//           readout. Define PLOT_FB_DROP_COUNT_EN to add the drop_count port.
// Rev 1.0
// ============================================================================
`default_nettype none

module plot_fb (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clear,
  input  logic [2:0]  clear_colour,
  input  logic        start_scan,
  output logic        busy,
  output logic [7:0]  pix_x,
  output logic [6:0]  pix_y,
  output logic [2:0]  pix_colour,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        scan_done
`ifdef PLOT_FB_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int          c_depth     = 19200;
  localparam logic [14:0] c_last_addr = 15'd19199;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SCAN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [2:0]  r_mem [0:c_depth-1];
  logic [14:0] r_clr_addr;
  logic [2:0]  r_clr_colour;
  logic [14:0] r_iss_addr;
  logic [7:0]  r_iss_x;
  logic [6:0]  r_iss_y;
  logic        r_iss_done;
  logic        r_rd_vld;
  logic [7:0]  r_rd_x;
  logic [6:0]  r_rd_y;
  logic [2:0]  r_rd_data;

  logic        w_in_range;
  logic        w_plot_wr;
  logic [14:0] w_plot_addr;
  logic        w_clr_wr;
  logic        w_wr_en;
  logic [14:0] w_wr_addr;
  logic [2:0]  w_wr_data;
  logic        w_adv;
  logic        w_rd_en;
  logic        w_last_acc;

  // y*160 + x as y*128 + y*32 + x
  assign w_plot_addr = 15'({vga_y, 7'b0}) + 15'({vga_y, 5'b0}) + 15'(vga_x);
  assign w_in_range  = (vga_x < 8'd160) && (vga_y < 7'd120);
  assign w_plot_wr   = vga_plot && w_in_range && (r_state != S_CLEAR);
  assign w_clr_wr    = (r_state == S_CLEAR);
  assign w_wr_en     = !rst && (w_plot_wr || w_clr_wr);
  assign w_wr_addr   = w_clr_wr ? r_clr_addr : w_plot_addr;
  assign w_wr_data   = w_clr_wr ? r_clr_colour : vga_colour;

  // The whole readout pipeline moves together, stalling only on a held output.
  assign w_adv       = !pix_valid || pix_ready;
  assign w_rd_en     = (r_state == S_SCAN) && w_adv && !r_iss_done;
  assign w_last_acc  = pix_valid && pix_ready && (pix_x == 8'd159) && (pix_y == 7'd119);

  // Read-before-write: a same-address plot and readout returns the old value.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
    if (w_rd_en) begin
      r_rd_data <= r_mem[r_iss_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      busy         <= 1'b0;
      scan_done    <= 1'b0;
      pix_valid    <= 1'b0;
      pix_x        <= 8'd0;
      pix_y        <= 7'd0;
      pix_colour   <= 3'd0;
      r_clr_addr   <= 15'd0;
      r_clr_colour <= 3'd0;
      r_iss_addr   <= 15'd0;
      r_iss_x      <= 8'd0;
      r_iss_y      <= 7'd0;
      r_iss_done   <= 1'b1;
      r_rd_vld     <= 1'b0;
      r_rd_x       <= 8'd0;
      r_rd_y       <= 7'd0;
    end else begin
      scan_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_state      <= S_CLEAR;
            busy         <= 1'b1;
            r_clr_addr   <= 15'd0;
            r_clr_colour <= clear_colour;
          end else if (start_scan) begin
            r_state    <= S_SCAN;
            busy       <= 1'b1;
            r_iss_addr <= 15'd0;
            r_iss_x    <= 8'd0;
            r_iss_y    <= 7'd0;
            r_iss_done <= 1'b0;
            r_rd_vld   <= 1'b0;
            pix_valid  <= 1'b0;
          end
        end

        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 15'd1;
          if (r_clr_addr == c_last_addr) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        S_SCAN: begin
          if (w_last_acc) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            scan_done <= 1'b1;
            r_rd_vld  <= 1'b0;
          end else if (w_adv) begin
            if (!r_iss_done) begin
              r_rd_vld   <= 1'b1;
              r_rd_x     <= r_iss_x;
              r_rd_y     <= r_iss_y;
              r_iss_addr <= r_iss_addr + 15'd1;
              if (r_iss_x == 8'd159) begin
                r_iss_x <= 8'd0;
                r_iss_y <= r_iss_y + 7'd1;
              end else begin
                r_iss_x <= r_iss_x + 8'd1;
              end
              if (r_iss_addr == c_last_addr) begin
                r_iss_done <= 1'b1;
              end
            end else begin
              r_rd_vld <= 1'b0;
            end
            pix_valid <= r_rd_vld;
            if (r_rd_vld) begin
              pix_x      <= r_rd_x;
              pix_y      <= r_rd_y;
              pix_colour <= r_rd_data;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLOT_FB_DROP_COUNT_EN
  logic w_drop;
  assign w_drop = vga_plot && (!w_in_range || (r_state == S_CLEAR));

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= 16'd0;
    end else if (w_drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_plot_fb.sv
// ============================================================================
// tb_plot_fb : directed self-checking bench for plot_fb.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_plot_fb;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        clear;
  logic [2:0]  clear_colour;
  logic        start_scan;
  logic        busy;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_colour;
  logic        pix_valid;
  logic        pix_ready;
  logic        scan_done;
`ifdef PLOT_FB_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  plot_fb dut (
    .clk          (clk),
    .rst          (rst),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .clear        (clear),
    .clear_colour (clear_colour),
    .start_scan   (start_scan),
    .busy         (busy),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_colour   (pix_colour),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .scan_done    (scan_done)
`ifdef PLOT_FB_DROP_COUNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] cap [0:19199];
  int         n_pix, first_vld, ord_err, stall_err, done_cnt, end_bad;
  int         clr_cycles;
  logic       clr_busy_rose;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Picture left behind by test_plot_drop.
  function automatic logic [2:0] exp_pat(input int i);
    if (i == 0)     return 3'd7;
    if (i == 19199) return 3'd5;
    if (i == 9680)  return 3'd3;
    return 3'd0;
  endfunction

  task automatic plot_px(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1'b1;
    tick;
    vga_plot = 1'b0;
  endtask

  // Clear, optionally plotting (1,0)/(2,0) at two cycle offsets into CLEAR.
  task automatic do_clear(input logic [2:0] col, input int drop_a, input int drop_b);
    clear = 1'b1; clear_colour = col;
    tick;
    clear = 1'b0; clear_colour = ~col;
    clr_busy_rose = busy;
    clr_cycles = 0;
    while (busy && clr_cycles < 25000) begin
      vga_plot   = (clr_cycles == drop_a) || (clr_cycles == drop_b);
      vga_x      = (clr_cycles == drop_a) ? 8'd1 : 8'd2;
      vga_y      = 7'd0;
      vga_colour = 3'd4;
      tick;
      clr_cycles++;
    end
    vga_plot = 1'b0;
  endtask

  // rmode 1: random pix_ready for the first 1000 pixels. Plots (10,0)=6 at plot_cyc.
  task automatic run_scan(input int rmode, input int max_pix, input int plot_cyc);
    int         cyc;
    logic       held;
    logic [7:0] hx;
    logic [6:0] hy;
    logic [2:0] hc;
    n_pix = 0; first_vld = -1; ord_err = 0; stall_err = 0; done_cnt = 0; end_bad = 0;
    held = 1'b0; hx = '0; hy = '0; hc = '0;
    start_scan = 1'b1;
    tick;
    start_scan = 1'b0;
    cyc = 0;
    forever begin
      if (held) begin
        if (!pix_valid || pix_x !== hx || pix_y !== hy || pix_colour !== hc) stall_err++;
        held = 1'b0;
      end
      if (scan_done) begin
        done_cnt++;
        if (pix_valid || busy) end_bad++;
      end
      if (pix_valid && first_vld < 0) first_vld = cyc;
      if (done_cnt > 0 || n_pix >= max_pix || cyc >= 60000) break;
      vga_plot = (cyc == plot_cyc); vga_x = 8'd10; vga_y = 7'd0; vga_colour = 3'd6;
      pix_ready = (rmode == 1 && n_pix < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid) begin
        if (pix_ready) begin
          if (pix_x !== 8'(n_pix % 160) || pix_y !== 7'(n_pix / 160)) ord_err++;
          if (n_pix < 19200) cap[n_pix] = pix_colour;
          n_pix++;
        end else begin
          held = 1'b1; hx = pix_x; hy = pix_y; hc = pix_colour;
        end
      end
      tick;
      cyc++;
    end
    vga_plot = 1'b0;
    pix_ready = 1'b1;
    if (done_cnt > 0) begin
      tick;
      if (scan_done) done_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; vga_x = 8'd0; vga_y = 7'd0; vga_colour = 3'd0; vga_plot = 1'b0;
    clear = 1'b0; clear_colour = 3'd0; start_scan = 1'b0; pix_ready = 1'b1;
    tick; tick;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", busy); else n_pass++;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %0d expected 0", pix_valid); else n_pass++;
    n_checks++; if (scan_done !== 1'b0) $display("FAIL reset_scan_done: got %0d expected 0", scan_done); else n_pass++;
    n_checks++; if (pix_x !== 8'd0) $display("FAIL reset_pix_x: got %0d expected 0", pix_x); else n_pass++;
    n_checks++; if (pix_y !== 7'd0) $display("FAIL reset_pix_y: got %0d expected 0", pix_y); else n_pass++;
    n_checks++; if (pix_colour !== 3'd0) $display("FAIL reset_pix_colour: got %0d expected 0", pix_colour); else n_pass++;
`ifdef PLOT_FB_DROP_COUNT_EN
    n_checks++; if (drop_count !== 16'd0) $display("FAIL reset_drop_count: got %0d expected 0", drop_count); else n_pass++;
`endif
    rst = 1'b0;
    tick;
  endtask

  task automatic test_clear_fill;
    int bad;
    do_clear(3'd2, -1, -1);
    n_checks++; if (clr_busy_rose !== 1'b1) $display("FAIL clear_busy_rise: got %0d expected 1", clr_busy_rose); else n_pass++;
    n_checks++; if (clr_cycles != 19200) $display("FAIL clear_cycles: got %0d expected 19200", clr_cycles); else n_pass++;
    run_scan(0, 19200, -1);
    bad = 0;
    for (int i = 0; i < n_pix; i++) if (cap[i] !== 3'd2) bad++;
    n_checks++; if (first_vld != 2) $display("FAIL fill_first_valid: got %0d expected 2", first_vld); else n_pass++;
    n_checks++; if (n_pix != 19200) $display("FAIL fill_pixel_count: got %0d expected 19200", n_pix); else n_pass++;
    n_checks++; if (ord_err != 0) $display("FAIL fill_order: got %0d errors expected 0", ord_err); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL fill_colour: got %0d wrong pixels expected 0", bad); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL fill_scan_done: got %0d pulses expected 1", done_cnt); else n_pass++;
    n_checks++; if (end_bad != 0) $display("FAIL fill_end_state: got %0d expected 0", end_bad); else n_pass++;
  endtask

  task automatic test_plot_drop;
    int bad, nz;
    do_clear(3'd0, 100, 200);
    n_checks++; if (clr_cycles != 19200) $display("FAIL clear0_cycles: got %0d expected 19200", clr_cycles); else n_pass++;
    plot_px(8'd0,   7'd0,   3'd7);
    plot_px(8'd159, 7'd119, 3'd5);
    plot_px(8'd80,  7'd60,  3'd3);
    plot_px(8'd160, 7'd0,   3'd6);
    plot_px(8'd0,   7'd120, 3'd6);
    plot_px(8'd255, 7'd127, 3'd6);
    run_scan(0, 19200, -1);
    bad = 0; nz = 0;
    for (int i = 0; i < n_pix; i++) begin
      if (cap[i] !== exp_pat(i)) bad++;
      if (cap[i] !== 3'd0) nz++;
    end
    n_checks++; if (n_pix != 19200) $display("FAIL plot_pixel_count: got %0d expected 19200", n_pix); else n_pass++;
    n_checks++; if (ord_err != 0) $display("FAIL plot_order: got %0d errors expected 0", ord_err); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL plot_pattern: got %0d wrong pixels expected 0", bad); else n_pass++;
    n_checks++; if (nz != 3) $display("FAIL plot_nonzero: got %0d expected 3", nz); else n_pass++;
    n_checks++; if (cap[9680] !== 3'd3) $display("FAIL plot_centre: got %0d expected 3", cap[9680]); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL plot_scan_done: got %0d pulses expected 1", done_cnt); else n_pass++;
`ifdef PLOT_FB_DROP_COUNT_EN
    n_checks++; if (drop_count !== 16'd5) $display("FAIL drop_count: got %0d expected 5", drop_count); else n_pass++;
`endif
  endtask

  task automatic test_backpressure_reset;
    int bad;
    run_scan(1, 5000, -1);
    bad = 0;
    for (int i = 0; i < n_pix; i++) if (cap[i] !== exp_pat(i)) bad++;
    n_checks++; if (n_pix != 5000) $display("FAIL bp_pixel_count: got %0d expected 5000", n_pix); else n_pass++;
    n_checks++; if (ord_err != 0) $display("FAIL bp_order: got %0d errors expected 0", ord_err); else n_pass++;
    n_checks++; if (stall_err != 0) $display("FAIL bp_stall_hold: got %0d errors expected 0", stall_err); else n_pass++;
    n_checks++; if (bad != 0) $display("FAIL bp_pattern: got %0d wrong pixels expected 0", bad); else n_pass++;
    rst = 1'b1;
    tick;
    n_checks++; if (pix_valid !== 1'b0) $display("FAIL midrst_pix_valid: got %0d expected 0", pix_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0d expected 0", busy); else n_pass++;
    n_checks++; if (pix_x !== 8'd0) $display("FAIL midrst_pix_x: got %0d expected 0", pix_x); else n_pass++;
`ifdef PLOT_FB_DROP_COUNT_EN
    n_checks++; if (drop_count !== 16'd0) $display("FAIL midrst_drop_count: got %0d expected 0", drop_count); else n_pass++;
`endif
    rst = 1'b0;
    tick;
  endtask

  task automatic test_plot_during_read;
    run_scan(0, 20, 10);
    n_checks++; if (first_vld != 2) $display("FAIL restart_first_valid: got %0d expected 2", first_vld); else n_pass++;
    n_checks++; if (ord_err != 0 || n_pix != 20) $display("FAIL restart_order: got %0d errors %0d pixels expected 0 errors 20 pixels", ord_err, n_pix); else n_pass++;
    n_checks++; if (cap[10] !== 3'd0) $display("FAIL collide_old_value: got %0d expected 0", cap[10]); else n_pass++;
    rst = 1'b1; tick; rst = 1'b0; tick;
    run_scan(0, 20, -1);
    n_checks++; if (cap[10] !== 3'd6) $display("FAIL collide_new_value: got %0d expected 6", cap[10]); else n_pass++;
    n_checks++; if (cap[9] !== 3'd0) $display("FAIL collide_neighbour: got %0d expected 0", cap[9]); else n_pass++;
    rst = 1'b1; tick; rst = 1'b0; tick;
  endtask

  initial begin
    test_reset;
    test_clear_fill;
    test_plot_drop;
    test_backpressure_reset;
    test_plot_during_read;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/plot_fb.md
PLOT_FB -- requirements
Module: plot_fb

Interface
REQ-001 SHALL have clk  input  1  sole clock; all logic rising-edge.
REQ-002 SHALL have rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have vga_x  input  8  plot column, valid 0..159.
REQ-004 SHALL have vga_y  input  7  plot row, valid 0..119.
REQ-005 SHALL have vga_colour  input  3  plot colour.
REQ-006 SHALL have vga_plot  input  1  write strobe, one pixel per asserted cycle.
REQ-007 SHALL have clear  input  1  request fill of framebuffer with clear_colour.
REQ-008 SHALL have clear_colour  input  3  fill colour, sampled when clear is accepted.
REQ-009 SHALL have start_scan  input  1  request raster readout.
REQ-010 SHALL have busy  output  1  high in CLEAR or SCAN.
REQ-011 SHALL have pix_x / pix_y / pix_colour  output  8/7/3  readout pixel.
REQ-012 SHALL have pix_valid  output  1; pix_ready  input  1  readout handshake.
REQ-013 SHALL have scan_done  output  1  one-cycle pulse after last readout pixel is accepted.
REQ-014 SHALL have drop_count  output  16  dropped-plot counter (present only with PLOT_FB_DROP_COUNT_EN).

Function
REQ-015 SHALL store 160x120x3-bit framebuffer; address = y*160 + x; one write port, one synchronous read port (1-cycle latency).
REQ-016 SHALL implement FSM IDLE, CLEAR, SCAN; priority in IDLE: clear over start_scan; start_scan/clear ignored outside IDLE.
REQ-017 SHALL write vga_colour to (vga_x,vga_y) on the cycle after vga_plot high in IDLE or SCAN, when x<160 and y<120.
REQ-018 SHALL drop plots with x>=160 or y>=120, and all plots during CLEAR; memory unchanged.
REQ-019 CLEAR SHALL write clear_colour to addresses 0..19199, one per cycle, then return to IDLE; exactly 19200 cycles in CLEAR.
REQ-020 SCAN SHALL emit all 19200 pixels in raster order (x fastest), pix_x/pix_y matching address.
REQ-021 First pix_valid SHALL assert exactly 2 cycles after start_scan accepted, when pix_ready held high.
REQ-022 With pix_ready held high, SHALL sustain one pixel per cycle.
REQ-023 While pix_valid && !pix_ready, pix_x/pix_y/pix_colour/pix_valid SHALL hold stable; no pixel lost or duplicated.
REQ-024 After (159,119) accepted, SHALL pulse scan_done next cycle, deassert pix_valid, return to IDLE.
REQ-025 Plot and readout of same address same cycle: readout SHALL return the old value.
REQ-026 busy SHALL rise the cycle after clear/start_scan accepted and fall the cycle IDLE re-entered.

Reset
REQ-027 rst SHALL force IDLE, busy=0, pix_valid=0, scan_done=0, pix_x=0, pix_y=0, pix_colour=0, drop_count=0, any cycle including mid-CLEAR/SCAN.
REQ-028 Framebuffer contents SHALL NOT be modified by reset; content is undefined until written or cleared.
REQ-029 Plots in the reset cycle SHALL be ignored.

Configuration
REQ-030 With PLOT_FB_DROP_COUNT_EN defined, drop_count SHALL increment by 1 per dropped plot (REQ-018), saturating at 65535.
REQ-031 Without PLOT_FB_DROP_COUNT_EN, port drop_count SHALL be absent and no counter logic built; all other behaviour identical.

Verification
REQ-032 rst, clear with clear_colour=3'b010, wait busy low, scan with pix_ready=1 -> 19200 pixels all colour 2, first pix_valid 2 cycles after start, scan_done once.
REQ-033 After clear to 0, plot (0,0)=7, (159,119)=5, (80,60)=3, then scan -> exactly those three nonzero, at raster indices 0, 19199, 9680.
REQ-034 Plot (160,0), (0,120), (255,127), plus 2 plots during CLEAR -> memory unchanged; drop_count=5 with macro, port absent without.
REQ-035 Scan with pix_ready random 50% -> output sequence identical to pix_ready=1 run; held values stable during stalls.
REQ-036 rst asserted at pixel 5000 of scan -> next cycle pix_valid=0, busy=0; new start_scan restarts at (0,0).
REQ-037 Plot (10,0)=6 in the cycle pixel (10,0) is read -> scan emits old value; subsequent scan emits 6.
